// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline register with optional skid entry,
// flush, NOP fill on bubbles and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter bit               SKID      = 1'b1,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             clr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             emit;
  logic             stall;

  assign accept = in_valid && in_ready;
  assign emit   = main_valid && out_ready;
  assign stall  = main_valid && !out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : NOP_VALUE;

  if (SKID) begin : g_skid
    // Registered ready: only the skid occupancy gates upstream.
    assign in_ready = !skid_valid;

    // Skid entry catches a beat that arrives while main is stalled.
    always_ff @(posedge clk) begin
      if (rst) begin
        skid_valid <= 1'b0;
        skid_data  <= NOP_VALUE;
      end else if (flush) begin
        skid_valid <= 1'b0;
      end else if (emit && skid_valid) begin
        skid_valid <= 1'b0;
      end else if (accept && main_valid && !emit) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end else begin : g_noskid
    // Single entry: ready follows downstream combinationally.
    assign in_ready   = !main_valid || out_ready;
    assign skid_valid = 1'b0;
    assign skid_data  = NOP_VALUE;
  end

  // Main register: refill from skid first so order is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= NOP_VALUE;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (emit && skid_valid) begin
      main_data  <= skid_data;
    end else if (accept && (emit || !main_valid)) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end else if (emit) begin
      main_valid <= 1'b0;
    end
  end

  // Stall counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg with skid,
// without skid, and with a narrow saturating counter.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [15:0] stall_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic [1:0]  stall_cnt2;

  logic        flush0 = 1'b0;
  logic        clr0 = 1'b0;
  logic        in_valid0 = 1'b0;
  logic [31:0] in_data0 = '0;
  logic        out_ready0 = 1'b0;
  logic        in_ready0;
  logic        out_valid0;
  logic [31:0] out_data0;
  logic [15:0] stall_cnt0;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH(32), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stall_cnt(stall_cnt), .clr_cnt(clr)
  );

  pipe_stage_reg #(
    .WIDTH(32), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_W(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
    .stall_cnt(stall_cnt2), .clr_cnt(clr)
  );

  pipe_stage_reg #(
    .WIDTH(32), .NOP_VALUE(NOP), .SKID(1'b0), .CNT_W(16)
  ) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready0),
    .stall_cnt(stall_cnt0), .clr_cnt(clr0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    // 1: reset two cycles, then idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_odata", out_data, NOP);
    chk("rst_iready", 32'(in_ready), 32'd1);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_cnt2", 32'(stall_cnt2), 32'd0);
    chk("rst_iready2", 32'(in_ready2), 32'd1);
    chk("rst_iready0", 32'(in_ready0), 32'd1);

    // 2: back-to-back stream with skid build
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h11;
    tick();
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_data", out_data, 32'h11);
    in_data = 32'h22;
    tick();
    chk("s2_data", out_data, 32'h22);
    chk("s2_iready", 32'(in_ready), 32'd1);
    in_data = 32'h33;
    tick();
    chk("s3_data", out_data, 32'h33);
    in_valid = 1'b0;
    tick();
    chk("s4_valid", 32'(out_valid), 32'd0);
    chk("s4_data", out_data, NOP);
    chk("s4_cnt", 32'(stall_cnt), 32'd0);

    // 3: skid capture and ordered drain
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hAA;
    tick();
    chk("k1_data", out_data, 32'hAA);
    chk("k1_iready", 32'(in_ready), 32'd1);
    in_data = 32'hBB;
    tick();
    chk("k2_data", out_data, 32'hAA);
    chk("k2_iready", 32'(in_ready), 32'd0);
    in_data = 32'hCC;
    tick();
    chk("k3_hold", out_data, 32'hAA);
    chk("k3_iready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("k4_data", out_data, 32'hBB);
    chk("k4_iready", 32'(in_ready), 32'd1);
    tick();
    chk("k5_valid", 32'(out_valid), 32'd0);
    chk("k5_cnt", 32'(stall_cnt), 32'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("k6_clr", 32'(stall_cnt), 32'd0);

    // 4: stall counting and saturation
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("c5_cnt", 32'(stall_cnt), 32'd5);
    chk("c5_cnt2", 32'(stall_cnt2), 32'd3);
    chk("c5_data2", out_data2, 32'h77);
    tick();
    chk("c6_cnt", 32'(stall_cnt), 32'd6);
    chk("c6_cnt2", 32'(stall_cnt2), 32'd3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("c7_clr", 32'(stall_cnt), 32'd0);
    chk("c7_clr2", 32'(stall_cnt2), 32'd0);
    chk("c7_hold", out_data, 32'h77);
    chk("c7_valid2", 32'(out_valid2), 32'd1);

    // 5: flush with main and skid occupied
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h44;
    tick();
    in_data = 32'h55;
    tick();
    chk("f1_iready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    in_data = 32'h66;
    tick();
    flush = 1'b0;
    chk("f2_valid", 32'(out_valid), 32'd0);
    chk("f2_data", out_data, NOP);
    chk("f2_iready", 32'(in_ready), 32'd1);
    chk("f2_cnt", 32'(stall_cnt), 32'd2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("f3_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data = 32'h99;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("f4_drop", 32'(out_valid), 32'd0);

    // 6: reset mid-stream overrides flush and accept
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h12;
    tick();
    chk("r1_data", out_data, 32'h12);
    rst = 1'b1;
    flush = 1'b1;
    in_data = 32'h34;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("r2_valid", 32'(out_valid), 32'd0);
    chk("r2_data", out_data, NOP);
    chk("r2_iready", 32'(in_ready), 32'd1);
    chk("r2_cnt", 32'(stall_cnt), 32'd0);
    tick();
    chk("r3_valid", 32'(out_valid), 32'd0);

    // 6b: single-entry variant streams the same sequence
    out_ready0 = 1'b1;
    in_valid0 = 1'b1;
    in_data0 = 32'h11;
    tick();
    chk("n1_data", out_data0, 32'h11);
    in_data0 = 32'h22;
    tick();
    chk("n2_data", out_data0, 32'h22);
    in_data0 = 32'h33;
    tick();
    chk("n3_data", out_data0, 32'h33);
    chk("n3_valid", 32'(out_valid0), 32'd1);
    in_valid0 = 1'b0;
    out_ready0 = 1'b0;
    #1;
    chk("n4_iready", 32'(in_ready0), 32'd0);
    out_ready0 = 1'b1;
    #1;
    chk("n5_iready", 32'(in_ready0), 32'd1);
    tick();
    chk("n6_valid", 32'(out_valid0), 32'd0);
    chk("n6_data", out_data0, NOP);
    chk("n6_cnt", 32'(stall_cnt0), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
